// File: rtl/z16_program_loader_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// z16_program_loader_if : byte-stream input and instruction-memory write bus
// Revision: 1.0
// ----------------------------------------------------------------------------
interface z16_program_loader_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              i_rx_valid;
  logic [7:0]        i_rx_data;
  logic              o_rx_ready;
  logic              o_imem_we;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [15:0]       o_imem_wdata;

  // Loader side
  modport slave (
    input  i_rx_valid, i_rx_data,
    output o_rx_ready, o_imem_we, o_imem_addr, o_imem_wdata
  );

  // Byte source / memory side
  modport master (
    output i_rx_valid, i_rx_data,
    input  o_rx_ready, o_imem_we, o_imem_addr, o_imem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/z16_program_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// z16_program_loader : writes a checksummed byte-stream image into Z16 imem
// Revision: 1.0
// ----------------------------------------------------------------------------
module z16_program_loader #(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 256
) (
  input  wire logic            i_clk,
  input  wire logic            i_rst,
  z16_program_loader_if.slave  bus,
  output logic                 o_cpu_rst,
  output logic                 o_done,
  output logic                 o_err
);

  typedef enum logic [2:0] {
    S_LEN_LO  = 3'd0,
    S_LEN_HI  = 3'd1,
    S_DATA_LO = 3'd2,
    S_DATA_HI = 3'd3,
    S_CSUM    = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  state_t            r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_cnt;
  logic [7:0]        r_lo;
  logic [7:0]        r_csum;
  logic [ADDR_W-1:0] r_next_addr;

  logic        w_accept;
  logic [15:0] w_len;

  assign w_accept = bus.i_rx_valid && bus.o_rx_ready;
  assign w_len    = {bus.i_rx_data, r_len[7:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_LEN_LO;
      r_len            <= '0;
      r_cnt            <= '0;
      r_lo             <= '0;
      r_csum           <= '0;
      r_next_addr      <= BASE_ADDR;
      bus.o_rx_ready   <= 1'b0;
      bus.o_imem_we    <= 1'b0;
      bus.o_imem_addr  <= BASE_ADDR;
      bus.o_imem_wdata <= '0;
      o_cpu_rst        <= 1'b1;
      o_done           <= 1'b0;
      o_err            <= 1'b0;
    end else begin
      bus.o_imem_we <= 1'b0;
      case (r_state)
        S_LEN_LO: begin
          bus.o_rx_ready <= 1'b1;
          if (w_accept) begin
            r_len[7:0] <= bus.i_rx_data;
            r_state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          bus.o_rx_ready <= 1'b1;
          if (w_accept) begin
            r_len[15:8] <= bus.i_rx_data;
            if (32'(w_len) > 32'(MAX_WORDS)) begin
              r_state        <= S_ERR;
              bus.o_rx_ready <= 1'b0;
              o_err          <= 1'b1;
            end else if (w_len == 16'd0) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA_LO;
            end
          end
        end
        S_DATA_LO: begin
          bus.o_rx_ready <= 1'b1;
          if (w_accept) begin
            r_lo    <= bus.i_rx_data;
            r_csum  <= r_csum ^ bus.i_rx_data;
            r_state <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          bus.o_rx_ready <= 1'b1;
          if (w_accept) begin
            r_csum           <= r_csum ^ bus.i_rx_data;
            bus.o_imem_we    <= 1'b1;
            bus.o_imem_addr  <= r_next_addr;
            bus.o_imem_wdata <= {bus.i_rx_data, r_lo};
            r_next_addr      <= r_next_addr + ADDR_W'(2);
            r_cnt            <= r_cnt + 16'd1;
            // r_cnt still holds the index of the word being written
            if (r_cnt + 16'd1 == r_len) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA_LO;
            end
          end
        end
        S_CSUM: begin
          bus.o_rx_ready <= 1'b1;
          if (w_accept) begin
            bus.o_rx_ready <= 1'b0;
            if (bus.i_rx_data == r_csum) begin
              r_state   <= S_DONE;
              o_done    <= 1'b1;
              o_cpu_rst <= 1'b0;
            end else begin
              r_state <= S_ERR;
              o_err   <= 1'b1;
            end
          end
        end
        default: begin
          bus.o_rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_z16_program_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_z16_program_loader : directed image loads checked against a stream model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_z16_program_loader;

  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  logic rst;
  logic cpu_rst, done, err;

  always #5 clk = ~clk;

  z16_program_loader_if #(.ADDR_W(16)) bus ();

  z16_program_loader #(
    .ADDR_W    (16),
    .BASE_ADDR (16'h0000),
    .MAX_WORDS (256)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus),
    .o_cpu_rst (cpu_rst),
    .o_done    (done),
    .o_err     (err)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];   // expected writes {addr, data}
  logic [31:0] log_q[$];   // observed writes {addr, data}
  bit          exp_done, exp_err;
  logic        prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Expected writes and outcome derived directly from the stream format
  function automatic void model(input bytes_t s);
    int unsigned n;
    logic [7:0]  cs;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (s.size() < 2) return;
    n = {s[1], s[0]};
    if (n > 256) begin
      exp_err = 1'b1;
      return;
    end
    cs = 8'h00;
    for (int k = 0; k < int'(n); k++) begin
      if (3 + 2 * k >= s.size()) return;
      cs = cs ^ s[2 + 2 * k] ^ s[3 + 2 * k];
      exp_q.push_back({16'(2 * k), s[3 + 2 * k], s[2 + 2 * k]});
    end
    if (s.size() > 2 + 2 * n) begin
      if (s[2 + 2 * n] == cs) exp_done = 1'b1;
      else                    exp_err  = 1'b1;
    end
  endfunction

  function automatic logic [31:0] logat(input int i);
    return (i < log_q.size()) ? log_q[i] : 32'hDEAD_DEAD;
  endfunction

  always @(negedge clk) begin
    if (bus.o_imem_we) begin
      log_q.push_back({bus.o_imem_addr, bus.o_imem_wdata});
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_write: got %0h expected none", {bus.o_imem_addr, bus.o_imem_wdata});
      end else begin
        chk("write", {bus.o_imem_addr, bus.o_imem_wdata}, exp_q.pop_front());
      end
      chk("strobe_width", {31'd0, prev_we}, 32'd0);
    end
    prev_we = bus.o_imem_we;
    chk("cpu_rst_vs_done", {31'd0, cpu_rst}, {31'd0, ~done});
    chk("done_err_exclusive", {31'd0, done & err}, 32'd0);
    if (done || err) chk("ready_terminal", {31'd0, bus.o_rx_ready}, 32'd0);
  end

  task automatic reset_dut();
    rst = 1'b1;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.o_rx_ready}, 32'd0);
    chk("rst_we",    {31'd0, bus.o_imem_we}, 32'd0);
    chk("rst_addr",  {16'd0, bus.o_imem_addr}, 32'h0000);
    chk("rst_wdata", {16'd0, bus.o_imem_wdata}, 32'h0000);
    chk("rst_state", {29'd0, cpu_rst, done, err}, 32'b100);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", {31'd0, bus.o_rx_ready}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    while (!bus.o_rx_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_rx_ready) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout: got ready 0 expected 1 for byte %0h", b);
    end
    @(posedge clk);
    #1 bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input bytes_t s, input bit gap);
    foreach (s[i]) begin
      send_byte(s[i]);
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic load(input string name, input bytes_t s, input bit gap);
    model(s);
    log_q.delete();
    send_bytes(s, gap);
    repeat (3) @(negedge clk);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_done"}, {31'd0, done}, {31'd0, exp_done});
    chk({name, "_err"},  {31'd0, err},  {31'd0, exp_err});
    chk({name, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, ~exp_done});
  endtask

  bytes_t s;

  initial begin
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    rst = 1'b1;

    reset_dut();
    s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
    load("t1", s, 1'b0);
    chk("t1_nwr", log_q.size(), 2);
    chk("t1_w0", logat(0), 32'h0000_1234);
    chk("t1_w1", logat(1), 32'h0002_ABCD);
    chk("t1_done_lit", {31'd0, done}, 32'd1);
    chk("t1_ready", {31'd0, bus.o_rx_ready}, 32'd0);

    reset_dut();
    s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h41};
    load("t2", s, 1'b0);
    chk("t2_nwr", log_q.size(), 2);
    chk("t2_flags", {29'd0, cpu_rst, done, err}, 32'b101);

    reset_dut();
    s = '{8'h01, 8'h01};
    load("t3", s, 1'b0);
    chk("t3_nwr", log_q.size(), 0);
    chk("t3_flags", {28'd0, bus.o_rx_ready, cpu_rst, done, err}, 32'b0101);

    reset_dut();
    s = '{8'h00, 8'h00, 8'h00};
    load("t4", s, 1'b0);
    chk("t4_nwr", log_q.size(), 0);
    chk("t4_flags", {29'd0, cpu_rst, done, err}, 32'b010);

    reset_dut();
    s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'h51};
    load("t5", s, 1'b1);
    chk("t5_nwr", log_q.size(), 1);
    chk("t5_w0", logat(0), 32'h0000_BEEF);
    chk("t5_done_lit", {31'd0, done}, 32'd1);

    reset_dut();
    s = '{8'h03, 8'h00, 8'h34};
    model(s);
    log_q.delete();
    send_bytes(s, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_cpu", {31'd0, cpu_rst}, 32'd1);
    chk("t6_rst_we", {31'd0, bus.o_imem_we}, 32'd0);
    chk("t6_rst_addr", {16'd0, bus.o_imem_addr}, 32'h0000);
    chk("t6_nwr_partial", log_q.size(), 0);
    reset_dut();
    s = '{8'h01, 8'h00, 8'h34, 8'h12, 8'h26};
    load("t6", s, 1'b0);
    chk("t6_w0", logat(0), 32'h0000_1234);
    chk("t6_done_lit", {31'd0, done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
